// File: rtl/botao_if.sv
// Button conditioner signal bundle: raw pin in, clean level and pulses out.
interface botao_if;
    logic botao_bruto;
    logic botao_estavel;
    logic pulso_press;
    logic pulso_solta;

    modport master (
        output botao_bruto,
        input  botao_estavel,
        input  pulso_press,
        input  pulso_solta
    );

    modport slave (
        input  botao_bruto,
        output botao_estavel,
        output pulso_press,
        output pulso_solta
    );
endinterface

// File: rtl/condicionador_botao.sv
// Push-button conditioner: polarity fix, 2-FF synchronizer, debounce FSM,
// registered clean level plus one-cycle press/release pulses.
module condicionador_botao #(
    parameter int   DEBOUNCE_CICLOS     = 500000,
    parameter logic ENTRADA_ATIVA_BAIXA = 1'b1
) (
    input logic   clock,
    input logic   reset,
    botao_if.slave bt
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CONT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        SOLTO          = 2'b00,
        CONFIRMA_PRESS = 2'b01,
        PRESSIONADO    = 2'b10,
        CONFIRMA_SOLTA = 2'b11
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cont;
    logic          sync1;
    logic          sync2;
    logic          ativo;

    // Fold polarity in before the synchronizer so sync2 is always 1 = pressed.
    assign ativo = bt.botao_bruto ^ ENTRADA_ATIVA_BAIXA;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1            <= 1'b0;
            sync2            <= 1'b0;
            cont             <= '0;
            estado           <= SOLTO;
            bt.botao_estavel <= 1'b0;
            bt.pulso_press   <= 1'b0;
            bt.pulso_solta   <= 1'b0;
        end else begin
            sync1          <= ativo;
            sync2          <= sync1;
            bt.pulso_press <= 1'b0;
            bt.pulso_solta <= 1'b0;
            unique case (estado)
                SOLTO: begin
                    if (sync2) begin
                        estado <= CONFIRMA_PRESS;
                        cont   <= '0;
                    end
                end
                CONFIRMA_PRESS: begin
                    if (!sync2) begin
                        estado <= SOLTO;
                    end else if (cont == CONT_FIM) begin
                        estado           <= PRESSIONADO;
                        bt.botao_estavel <= 1'b1;
                        bt.pulso_press   <= 1'b1;
                    end else begin
                        cont <= cont + CW'(1);
                    end
                end
                PRESSIONADO: begin
                    if (!sync2) begin
                        estado <= CONFIRMA_SOLTA;
                        cont   <= '0;
                    end
                end
                CONFIRMA_SOLTA: begin
                    if (sync2) begin
                        estado <= PRESSIONADO;
                    end else if (cont == CONT_FIM) begin
                        estado           <= SOLTO;
                        bt.botao_estavel <= 1'b0;
                        bt.pulso_solta   <= 1'b1;
                    end else begin
                        cont <= cont + CW'(1);
                    end
                end
                default: estado <= SOLTO;
            endcase
        end
    end
endmodule

// File: tb/tb_condicionador_botao.sv
// Bench for condicionador_botao: both pin polarities side by side,
// directed latency scenarios plus random stimulus against a run-length model.
module tb_condicionador_botao;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic press = 1'b0;

    int errors = 0;
    int checks = 0;

    botao_if bif1 ();
    botao_if bif0 ();

    assign bif1.botao_bruto = ~press;
    assign bif0.botao_bruto = press;

    condicionador_botao #(
        .DEBOUNCE_CICLOS    (D),
        .ENTRADA_ATIVA_BAIXA(1'b1)
    ) dut1 (
        .clock(clock),
        .reset(reset),
        .bt   (bif1.slave)
    );

    condicionador_botao #(
        .DEBOUNCE_CICLOS    (D),
        .ENTRADA_ATIVA_BAIXA(1'b0)
    ) dut0 (
        .clock(clock),
        .reset(reset),
        .bt   (bif0.slave)
    );

    always #5 clock = ~clock;

    logic [2:0] o1;
    logic [2:0] o0;
    assign o1 = {bif1.botao_estavel, bif1.pulso_press, bif1.pulso_solta};
    assign o0 = {bif0.botao_estavel, bif0.pulso_press, bif0.pulso_solta};

    // Reference: a level change is accepted once the synchronized input has
    // differed from the accepted level on D+1 consecutive edges.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0;
    logic m_press = 1'b0, m_solta = 1'b0;
    int   m_run = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
            m_run = 0; m_press = 1'b0; m_solta = 1'b0;
        end else begin
            m_press = 1'b0;
            m_solta = 1'b0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    if (m_lvl) m_press = 1'b1;
                    else       m_solta = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = press;
        end
    end

    logic [2:0] m_exp;
    assign m_exp = {m_lvl, m_press, m_solta};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle(input logic lvl);
        press = lvl;
        repeat (2 * D + 6) step();
    endtask

    task automatic test_reset();
        logic [2:0] e;
        e = 3'b000;
        reset = 1'b1;
        press = 1'b1;
        repeat (3) step();
        checks += 2;
        if (o1 !== e) begin
            errors++;
            $display("FAIL reset dut1 got=%b exp=%b", o1, e);
        end
        if (o0 !== e) begin
            errors++;
            $display("FAIL reset dut0 got=%b exp=%b", o0, e);
        end
        press = 1'b0;
        step();
        reset = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_press_clean();
        logic [2:0] e;
        settle(1'b0);
        press = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            e = {k >= 7, k == 7, 1'b0};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL press_clean k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL press_clean k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
    endtask

    task automatic test_short_press();
        logic [2:0] e;
        e = 3'b000;
        settle(1'b0);
        press = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) press = 1'b0;
            step();
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL short_press k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL short_press k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
    endtask

    task automatic test_window();
        logic [2:0] e;
        settle(1'b0);
        press = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) press = 1'b0;
            step();
            e = {k >= 7 && k <= 11, k == 7, k == 12};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL window k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL window k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] e;
        int np;
        settle(1'b0);
        e = 3'b000;
        for (int k = 0; k < 12; k++) begin
            press = ((k / 2) % 2) == 0;
            step();
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL bounce_phase k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL bounce_phase k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
        press = 1'b1;
        np = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            np += int'(bif1.pulso_press);
            e = {k >= 7, k == 7, 1'b0};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL bounce k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL bounce k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
        checks++;
        if (np !== 1) begin
            errors++;
            $display("FAIL bounce_count got=%0d exp=1", np);
        end
    endtask

    task automatic test_release();
        logic [2:0] e;
        settle(1'b1);
        press = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            e = {k < 7, 1'b0, k == 7};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL release k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL release k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
        settle(1'b1);
        e = 3'b100;
        press = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) press = 1'b1;
            step();
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL release_glitch k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL release_glitch k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        settle(1'b0);
        press = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        e = 3'b000;
        checks += 2;
        if (o1 !== e) begin
            errors++;
            $display("FAIL reset_mid dut1 got=%b exp=%b", o1, e);
        end
        if (o0 !== e) begin
            errors++;
            $display("FAIL reset_mid dut0 got=%b exp=%b", o0, e);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            e = {k >= 7, k == 7, 1'b0};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        e = 3'b000;
        checks += 2;
        if (o1 !== e) begin
            errors++;
            $display("FAIL reset_held dut1 got=%b exp=%b", o1, e);
        end
        if (o0 !== e) begin
            errors++;
            $display("FAIL reset_held dut0 got=%b exp=%b", o0, e);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            e = {k >= 7, k == 7, 1'b0};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL reset_held_after k=%0d dut1 got=%b exp=%b", k, o1, e);
            end
            if (o0 !== e) begin
                errors++;
                $display("FAIL reset_held_after k=%0d dut0 got=%b exp=%b", k, o0, e);
            end
        end
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int k = 0; k < 1500; k++) begin
            if (run == 0) begin
                press = 1'($urandom_range(1, 0));
                run = int'($urandom_range(9, 1));
            end
            run--;
            reset = ($urandom_range(199, 0) == 0);
            step();
            checks += 3;
            if (o1 !== m_exp) begin
                errors++;
                $display("FAIL random k=%0d dut1 got=%b exp=%b", k, o1, m_exp);
            end
            if (o0 !== m_exp) begin
                errors++;
                $display("FAIL random k=%0d dut0 got=%b exp=%b", k, o0, m_exp);
            end
            if (bif1.pulso_press && bif1.pulso_solta) begin
                errors++;
                $display("FAIL random_exclusive k=%0d got=11 exp=not both", k);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press_clean();
        test_short_press();
        test_window();
        test_bounce();
        test_release();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
